// File: rtl/dbus_router.sv
// Data-bus router: kseg0/kseg1 translation, then one request at a time on the cached or uncached port.
// Optional build macro DBUS_ROUTER_CACHE_BYPASS_EN sends every request to the uncached port.
module dbus_router (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        creq_valid,
  output logic [31:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [3:0]  creq_strobe,
  output logic [31:0] creq_data,
  input  logic        cresp_addr_ok,
  input  logic        cresp_data_ok,
  input  logic [31:0] cresp_data,
  output logic        ureq_valid,
  output logic [31:0] ureq_addr,
  output logic [2:0]  ureq_size,
  output logic [3:0]  ureq_strobe,
  output logic [31:0] ureq_data,
  input  logic        uresp_addr_ok,
  input  logic        uresp_data_ok,
  input  logic [31:0] uresp_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [31:0] paddr_q, wdata_q, rdata_q;
  logic [2:0]  size_q;
  logic [3:0]  strobe_q;
  logic        sel_u_q, cval_q, uval_q, dok_q;

  logic [31:0] paddr_d;
  logic        sel_u_d;
  logic        sel_addr_ok, sel_data_ok;
  logic [31:0] sel_data;

  always_comb begin
    paddr_d = dreq_addr;
    case (dreq_addr[31:28])
      4'h8, 4'hA: paddr_d[31:28] = 4'h0;
      4'h9, 4'hB: paddr_d[31:28] = 4'h1;
      default: ;
    endcase
  end

`ifdef DBUS_ROUTER_CACHE_BYPASS_EN
  assign sel_u_d = 1'b1;
`else
  assign sel_u_d = (dreq_addr[31:28] == 4'hA) || (dreq_addr[31:28] == 4'hB);
`endif

  assign sel_addr_ok = sel_u_q ? uresp_addr_ok : cresp_addr_ok;
  assign sel_data_ok = sel_u_q ? uresp_data_ok : cresp_data_ok;
  assign sel_data    = sel_u_q ? uresp_data    : cresp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      sel_u_q  <= 1'b0;
      cval_q   <= 1'b0;
      uval_q   <= 1'b0;
      dok_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq_valid) begin
            paddr_q  <= paddr_d;
            wdata_q  <= dreq_data;
            size_q   <= dreq_size;
            strobe_q <= dreq_strobe;
            sel_u_q  <= sel_u_d;
            cval_q   <= ~sel_u_d;
            uval_q   <= sel_u_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // data_ok without addr_ok here is deliberately ignored
          if (sel_addr_ok) begin
            cval_q <= 1'b0;
            uval_q <= 1'b0;
            if (sel_data_ok) begin
              rdata_q <= sel_data;
              dok_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sel_data_ok) begin
            rdata_q <= sel_data;
            dok_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          dok_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dresp_addr_ok = (state_q == IDLE) && dreq_valid;
  assign dresp_data_ok = dok_q;
  assign dresp_data    = rdata_q;

`ifdef DBUS_ROUTER_CACHE_BYPASS_EN
  assign creq_valid = 1'b0;
`else
  assign creq_valid = cval_q;
`endif
  assign creq_addr   = paddr_q;
  assign creq_size   = size_q;
  assign creq_strobe = strobe_q;
  assign creq_data   = wdata_q;

  assign ureq_valid  = uval_q;
  assign ureq_addr   = paddr_q;
  assign ureq_size   = size_q;
  assign ureq_strobe = strobe_q;
  assign ureq_data   = wdata_q;

endmodule

// File: tb/tb_dbus_router.sv
// Randomized scoreboard bench for dbus_router; a reference model predicts downstream requests and upstream responses.
// Honours DBUS_ROUTER_CACHE_BYPASS_EN when the design is built with it.
module tb_dbus_router;

  logic        clk = 1'b0, reset = 1'b1;
  logic        dreq_valid = 1'b0;
  logic [31:0] dreq_addr = '0, dreq_data = '0;
  logic [2:0]  dreq_size = '0;
  logic [3:0]  dreq_strobe = '0;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        creq_valid, ureq_valid;
  logic [31:0] creq_addr, ureq_addr, creq_data, ureq_data;
  logic [2:0]  creq_size, ureq_size;
  logic [3:0]  creq_strobe, ureq_strobe;
  logic        cresp_addr_ok = 1'b0, cresp_data_ok = 1'b0;
  logic        uresp_addr_ok = 1'b0, uresp_data_ok = 1'b0;
  logic [31:0] cresp_data = '0, uresp_data = '0;

  dbus_router dut (
    .clk(clk), .reset(reset),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_size(creq_size),
    .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_addr_ok(cresp_addr_ok), .cresp_data_ok(cresp_data_ok), .cresp_data(cresp_data),
    .ureq_valid(ureq_valid), .ureq_addr(ureq_addr), .ureq_size(ureq_size),
    .ureq_strobe(ureq_strobe), .ureq_data(ureq_data),
    .uresp_addr_ok(uresp_addr_ok), .uresp_data_ok(uresp_data_ok), .uresp_data(uresp_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total = 0, bad = 0;
  bit directed = 1'b0;
  bit busy = 1'b0;

  typedef struct {
    bit          u;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [3:0]  st;
    logic [31:0] d;
  } req_t;
  typedef struct {
    logic [31:0] d;
    int unsigned c;
  } resp_t;

  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // kseg0/kseg1 strip the top three address bits; kuseg/kseg2/kseg3 pass through
  function automatic logic [31:0] model_paddr(input logic [31:0] v);
    int unsigned seg;
    seg = v[31:28];
    if (seg >= 8 && seg <= 11) return v & 32'h1FFF_FFFF;
    return v;
  endfunction

  function automatic bit model_uncached(input logic [31:0] v);
`ifdef DBUS_ROUTER_CACHE_BYPASS_EN
    return 1'b1;
`else
    return (v >= 32'hA000_0000) && (v <= 32'hBFFF_FFFF);
`endif
  endfunction

  task automatic clear_resp();
    cresp_addr_ok = 1'b0; cresp_data_ok = 1'b0;
    uresp_addr_ok = 1'b0; uresp_data_ok = 1'b0;
  endtask

  task automatic drive_aok(input bit u);
    if (u) uresp_addr_ok = 1'b1; else cresp_addr_ok = 1'b1;
  endtask

  task automatic drive_dok(input bit u, input logic [31:0] d);
    if (u) begin uresp_data_ok = 1'b1; uresp_data = d; end
    else   begin cresp_data_ok = 1'b1; cresp_data = d; end
  endtask

  function automatic logic cur_valid(input bit u);
    return u ? ureq_valid : creq_valid;
  endfunction

  function automatic logic [31:0] cur_addr(input bit u);
    return u ? ureq_addr : creq_addr;
  endfunction

  // Downstream responder: random addr_ok/data_ok delays, garbage and cross-port noise
  initial begin : responder
    req_t        got, e;
    int unsigned stall;
    bit          zw;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      if (!directed) begin
        clear_resp();
        if (creq_valid || ureq_valid) begin
          got.u  = ureq_valid;
          got.a  = ureq_valid ? ureq_addr   : creq_addr;
          got.sz = ureq_valid ? ureq_size   : creq_size;
          got.st = ureq_valid ? ureq_strobe : creq_strobe;
          got.d  = ureq_valid ? ureq_data   : creq_data;
          if (exp_req_q.size() == 0) begin
            fail("req_unexpected", got.a, 32'h0);
          end else begin
            e = exp_req_q.pop_front();
            chk("req_port", {31'd0, got.u}, {31'd0, e.u});
            chk("req_addr", got.a, e.a);
            chk("req_size", {29'd0, got.sz}, {29'd0, e.sz});
            chk("req_strobe", {28'd0, got.st}, {28'd0, e.st});
            chk("req_data", got.d, e.d);
          end
          stall = $urandom_range(0, 3);
          for (int k = 0; k < int'(stall); k++) begin
            if ($urandom_range(0, 3) == 0) drive_dok(got.u, $urandom);
            if ($urandom_range(0, 1) == 1) drive_dok(!got.u, $urandom);
            @(negedge clk);
            clear_resp();
            chk("hold_valid", {31'd0, cur_valid(got.u)}, 32'd1);
            chk("hold_addr", cur_addr(got.u), got.a);
          end
          drive_aok(got.u);
          zw = ($urandom_range(0, 1) == 1);
          rd = $urandom;
          if (zw) begin
            drive_dok(got.u, rd);
            exp_resp_q.push_back('{d: rd, c: cyc + 1});
          end
          @(negedge clk);
          clear_resp();
          chk("valid_drop", {31'd0, creq_valid | ureq_valid}, 32'd0);
          if (!zw) begin
            stall = $urandom_range(0, 3);
            for (int k = 0; k < int'(stall); k++) begin
              if ($urandom_range(0, 1) == 1) drive_dok(!got.u, $urandom);
              @(negedge clk);
              clear_resp();
              chk("wait_valid_low", {31'd0, creq_valid | ureq_valid}, 32'd0);
            end
            drive_dok(got.u, rd);
            exp_resp_q.push_back('{d: rd, c: cyc + 1});
          end
        end
      end
    end
  end

  // Upstream monitor: pops the expected response whenever the DUT pulses dresp_data_ok
  always @(negedge clk) begin : monitor
    resp_t r;
    if (creq_valid && ureq_valid) fail("both_valid", 32'd1, 32'd0);
`ifdef DBUS_ROUTER_CACHE_BYPASS_EN
    if (creq_valid) fail("bypass_creq_valid", 32'd1, 32'd0);
`endif
    if (!reset && dresp_data_ok) begin
      if (exp_resp_q.size() == 0) begin
        fail("resp_unexpected", dresp_data, 32'h0);
      end else begin
        r = exp_resp_q.pop_front();
        chk("resp_data", dresp_data, r.d);
        chk("resp_cycle", cyc, r.c);
      end
      busy = 1'b0;
    end
  end

  logic [31:0] fixed_addr [5] = '{32'h8000_1234, 32'hBFC0_0010, 32'h0040_0000,
                                  32'hC000_0000, 32'h9000_0004};

  initial begin : stimulus
    logic [31:0] a;
    bit          acc;
    bit          u;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_creq_valid", {31'd0, creq_valid}, 32'd0);
    chk("rst_ureq_valid", {31'd0, ureq_valid}, 32'd0);
    chk("rst_dresp_data_ok", {31'd0, dresp_data_ok}, 32'd0);
    chk("rst_dresp_data", dresp_data, 32'd0);
    chk("rst_paddr", creq_addr, 32'd0);
    chk("rst_addr_ok", {31'd0, dresp_addr_ok}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      a = (i < 5) ? fixed_addr[i] : $urandom;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      dreq_valid  = 1'b1;
      dreq_addr   = a;
      dreq_size   = 3'($urandom);
      dreq_strobe = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
      dreq_data   = (i == 1) ? 32'h1234_5678 : $urandom;
      acc = 1'b0;
      for (int w = 0; w < 40 && !acc; w++) begin
        @(negedge clk);
        if (dresp_addr_ok) acc = 1'b1;
      end
      if (!acc) begin
        fail("accept_timeout", 32'd0, 32'd1);
      end else begin
        chk("accept_when_idle", {31'd0, busy}, 32'd0);
        busy = 1'b1;
        exp_req_q.push_back('{u: model_uncached(a), a: model_paddr(a), sz: dreq_size,
                              st: dreq_strobe, d: dreq_data});
      end
      @(posedge clk); #1;
      dreq_valid = 1'b0;
    end

    for (int w = 0; w < 50 && busy; w++) @(negedge clk);
    if (busy) fail("drain_timeout", 32'd1, 32'd0);
    chk("req_queue_empty", exp_req_q.size(), 32'd0);

    // Reset while the cached request sits in WAIT
    @(posedge clk); #1;
    directed = 1'b1;
    clear_resp();
    dreq_valid = 1'b1; dreq_addr = 32'h8000_0100; dreq_strobe = 4'b0000; dreq_size = 3'd2;
    @(negedge clk);
    chk("rt_accept", {31'd0, dresp_addr_ok}, 32'd1);
    @(posedge clk); #1;
    dreq_valid = 1'b0;
    @(negedge clk);
    u = model_uncached(32'h8000_0100);
    chk("rt_issue_valid", {31'd0, cur_valid(u)}, 32'd1);
    chk("rt_issue_addr", cur_addr(u), model_paddr(32'h8000_0100));
    drive_aok(u);
    @(posedge clk); #1;
    clear_resp();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rt_creq_valid", {31'd0, creq_valid}, 32'd0);
    chk("rt_ureq_valid", {31'd0, ureq_valid}, 32'd0);
    chk("rt_dresp_data_ok", {31'd0, dresp_data_ok}, 32'd0);
    chk("rt_dresp_data", dresp_data, 32'd0);
    @(negedge clk);
    drive_dok(u, 32'hAAAA_5555);
    @(negedge clk);
    clear_resp();
    for (int k = 0; k < 3; k++) begin
      chk("rt_late_ignored", {31'd0, dresp_data_ok}, 32'd0);
      @(negedge clk);
    end
    busy = 1'b0;

    // Recovery after reset: identity-mapped kseg2 address
    @(posedge clk); #1;
    dreq_valid = 1'b1; dreq_addr = 32'hC000_0000; dreq_strobe = 4'b0000;
    @(negedge clk);
    chk("rc_accept", {31'd0, dresp_addr_ok}, 32'd1);
    @(posedge clk); #1;
    dreq_valid = 1'b0;
    @(negedge clk);
    u = model_uncached(32'hC000_0000);
    chk("rc_valid", {31'd0, cur_valid(u)}, 32'd1);
    chk("rc_addr", cur_addr(u), 32'hC000_0000);
    drive_aok(u);
    drive_dok(u, 32'h600D_F00D);
    busy = 1'b1;
    exp_resp_q.push_back('{d: 32'h600D_F00D, c: cyc + 1});
    @(negedge clk);
    clear_resp();
    repeat (3) @(negedge clk);
    if (busy) fail("rc_no_response", 32'd0, 32'd1);
    chk("resp_queue_empty", exp_resp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbus_router.md
# dbus_router

Data-bus request router between the CPU core's memory stage and the two memory-side paths. It accepts one data request at a time on a virtual address and applies the fixed MIPS kseg0/kseg1 mapping. It then issues the request on either the cached port (toward the D-cache) or the uncached port (toward the uncached bus bridge), and returns that port's response to the core. It is the consumer end of the address-translation step: translation decides the path, and this block carries out the request on that path.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- dreq_valid  in  1  core request valid; held until dresp_addr_ok.
- dreq_addr  in  32  virtual address.
- dreq_size  in  3  access size code; passed through unchanged.
- dreq_strobe  in  4  byte write enables; 4'b0000 means read.
- dreq_data  in  32  write data.
- dresp_addr_ok  out  1  request accepted this cycle.
- dresp_data_ok  out  1  one-cycle response pulse.
- dresp_data  out  32  read data, valid with dresp_data_ok.
- creq_valid / ureq_valid  out  1  cached / uncached request valid.
- creq_addr / ureq_addr  out  32  physical address.
- creq_size / ureq_size  out  3  latched size.
- creq_strobe / ureq_strobe  out  4  latched strobe.
- creq_data / ureq_data  out  32  latched write data.
- cresp_addr_ok / uresp_addr_ok  in  1  downstream accepted the request.
- cresp_data_ok / uresp_data_ok  in  1  downstream response valid.
- cresp_data / uresp_data  in  32  downstream read data.

## Operation
- Translation is applied to dreq_addr at acceptance:
  - paddr[27:0] = vaddr[27:0].
  - paddr[31:28]: vaddr[31:28] of 0x8 or 0xA gives 0x0; 0x9 or 0xB gives 0x1; all other values are unchanged.
  - uncached = (vaddr[31:28] == 0xA) or (vaddr[31:28] == 0xB).
- The latched route bit `sel_u` selects the port. The unselected port's valid is 0.
- Unselected-port payload outputs carry the latched values. They are don't-care.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: dresp_addr_ok = dreq_valid. On dreq_valid, latch paddr, sel_u, size, strobe and data, then go to ISSUE.
  - ISSUE: assert the selected port's valid with the latched fields.
    - On that port's addr_ok and data_ok in the same cycle: latch data, go to RESP.
    - On addr_ok alone: go to WAIT.
    - Otherwise: stay in ISSUE, with payload held stable.
  - WAIT: valid deasserted. On the selected port's data_ok, latch data and go to RESP.
  - RESP: dresp_data_ok = 1 and dresp_data = latched data, for exactly one cycle, then go to IDLE.
- Responses on the unselected port are ignored.
- A data_ok in ISSUE without addr_ok is ignored. data_ok in IDLE or RESP is ignored.
- Writes take the same path. The latched dresp_data is whatever the downstream returns; the core ignores it.
- At most one request is outstanding. No new acceptance happens in ISSUE, WAIT or RESP.

## Timing
- Reset values:
  - FSM = IDLE.
  - dresp_addr_ok = 0 unless dreq_valid; it is combinational in IDLE.
  - dresp_data_ok = 0, dresp_data = 0.
  - creq_valid = ureq_valid = 0.
  - All latched payload registers = 0, sel_u = 0.
- Reset mid-operation: next cycle is IDLE with all valids 0, and the in-flight request is dropped. A downstream response arriving after reset is ignored.
- Minimum latency, with zero-wait downstream:
  - Cycle 0: accept.
  - Cycle 1: downstream valid, with addr_ok and data_ok both returned.
  - Cycle 2: dresp_data_ok.
- Back-to-back requests: the next acceptance is possible in cycle 3, so peak throughput is one request per 3 cycles.
- All outputs except dresp_addr_ok are driven from registers or FSM state only. There is no combinational path from downstream inputs to upstream outputs.

## Configuration
- DBUS_ROUTER_CACHE_BYPASS_EN defined:
  - sel_u is forced to 1 for every request, so all traffic goes to the uncached port.
  - creq_valid is tied 0.
  - Address translation is unchanged.
- Undefined: routing follows the uncached bit as described above.

## Test plan
- Cached read, zero-wait: vaddr 0x8000_1234, strobe 0.
  - Required: creq_valid with creq_addr 0x0000_1234 in cycle 1; ureq_valid stays 0.
  - Downstream returns 0xDEAD_BEEF with addr_ok and data_ok together: dresp_data_ok and dresp_data 0xDEAD_BEEF in cycle 2.
- Uncached write with stalls: vaddr 0xBFC0_0010, strobe 4'b1111, data 0x1234_5678.
  - Required: ureq_addr 0x1FC0_0010.
  - With uresp_addr_ok delayed 3 cycles, ureq_valid and payload stay stable for 4 cycles.
  - With uresp_data_ok 2 cycles later, a single dresp_data_ok pulse follows.
- Identity mapping: vaddr 0x0040_0000, then 0xC000_0000.
  - Required: the cached port carries paddr 0x0040_0000, then 0xC000_0000.
- Reset during WAIT: assert reset for 1 cycle after cached addr_ok.
  - Required: FSM in IDLE, no dresp_data_ok.
  - A cresp_data_ok arriving 2 cycles later is ignored.
- Cross-port noise: cached request in WAIT while uresp_data_ok pulses.
  - Required: no response until cresp_data_ok; dresp_data equals cresp_data.
- Bypass build with DBUS_ROUTER_CACHE_BYPASS_EN: vaddr 0x9000_0004.
  - Required: ureq_addr 0x1000_0004; creq_valid never asserts.
